// File: rtl/qif_neuron_scheduler.sv
// rtl/qif_neuron_scheduler.sv - time-multiplexed QIF neuron sweep with spike event output
//
// Purpose:
//   One quadratic integrate-and-fire update datapath shared by NUM_NEURONS
//   virtual neurons. Membrane values V and biases B live in small register
//   files. A step_start sweeps the neurons in index order; each neuron whose
//   pre-update V has reached V_PEAK is reset and reported as a spike event on
//   a valid/ready handshake before the sweep continues.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/cfg_addr/      bias write (IDLE only)
//   cfg_bias
//   clr_all               reset every V to V_RESET (IDLE only)
//   cfg_err               one-cycle pulse when cfg_we/clr_all arrive outside IDLE
//   step_start            start one sweep (IDLE only, otherwise ignored)
//   step_busy/step_done   sweep in progress / one-cycle completion pulse
//   evt_valid/evt_ready/  spike event stream; evt_id held until accepted
//   evt_id
//   rd_addr/rd_v          combinational debug read of V[rd_addr]

module qif_neuron_scheduler #(
  parameter int               NUM_NEURONS = 4,
  parameter logic signed [7:0] V_RESET     = -8'sd20,
  parameter logic signed [7:0] V_PEAK      = 8'sd50,
  localparam int              ID_W        = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [ID_W-1:0]        cfg_addr,
  input  logic signed [7:0]      cfg_bias,
  output logic                   cfg_err,
  input  logic                   clr_all,
  input  logic                   step_start,
  output logic                   step_busy,
  output logic                   step_done,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [ID_W-1:0]        evt_id,
  input  logic [ID_W-1:0]        rd_addr,
  output logic signed [7:0]      rd_v
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;
  logic cfg_err_q, cfg_err_d;

  logic signed [7:0] v_q [NUM_NEURONS];
  logic signed [7:0] v_d [NUM_NEURONS];
  logic signed [7:0] b_q [NUM_NEURONS];
  logic signed [7:0] b_d [NUM_NEURONS];

  // ---------------------------------------------------------------------------
  // Shared membrane-update datapath, operating on the neuron at idx_q
  // ---------------------------------------------------------------------------
  logic signed [7:0]  v_cur, b_cur, v_next;
  logic signed [15:0] v_ext, b_ext, b_shr, sq_term, sum;
  logic [15:0]        v_sq;
  logic               fire, last_idx;

  assign v_cur = v_q[idx_q];
  assign b_cur = b_q[idx_q];

  always_comb begin
    v_ext   = {{8{v_cur[7]}}, v_cur};
    b_ext   = {{8{b_cur[7]}}, b_cur};
    // V*V never exceeds 16384, so the 16-bit product is exact and non-negative.
    v_sq    = 16'(v_ext * v_ext);
    sq_term = 16'(v_sq >> 4);
    // Arithmetic shift floors toward minus infinity (-3 -> -1).
    b_shr   = b_ext >>> 2;
    sum     = v_ext + b_shr + sq_term;
    if (sum > 16'sd127) begin
      v_next = 8'sd127;
    end else if (sum < -16'sd128) begin
      v_next = -8'sd128;
    end else begin
      v_next = sum[7:0];
    end
  end

  // Firing is decided on the value before this step's update.
  assign fire     = (v_cur >= V_PEAK);
  assign last_idx = (idx_q == ID_W'(NUM_NEURONS - 1));

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        // Any same-cycle config lands at this edge, so the first CALC cycle
        // already sees it.
        if (step_start) begin
          state_d = ST_CALC;
          idx_d   = '0;
        end
      end
      ST_CALC: begin
        if (fire) begin
          state_d = ST_EMIT;
        end else if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
      ST_EMIT: begin
        if (evt_ready) begin
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
            idx_d   = idx_q + ID_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register-file next state
  // ---------------------------------------------------------------------------
  always_comb begin
    v_d       = v_q;
    b_d       = b_q;
    cfg_err_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (clr_all) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          v_d[i] = V_RESET;
        end
      end
      if (cfg_we) begin
        b_d[cfg_addr] = cfg_bias;
      end
    end else begin
      cfg_err_d = cfg_we | clr_all;
      if (state_q == ST_CALC) begin
        v_d[idx_q] = fire ? V_RESET : v_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= V_RESET;
        b_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_err_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= v_d[i];
        b_q[i] <= b_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cfg_err   = cfg_err_q;
  assign step_busy = (state_q == ST_CALC) || (state_q == ST_EMIT);
  assign step_done = (state_q == ST_DONE);
  assign evt_valid = (state_q == ST_EMIT);
  assign evt_id    = idx_q;
  assign rd_v      = v_q[rd_addr];

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// tb/tb_qif_neuron_scheduler.sv - self-checking bench for qif_neuron_scheduler

module tb_qif_neuron_scheduler;

  localparam int NN   = 4;
  localparam int ID_W = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 cfg_we;
  logic [ID_W-1:0]      cfg_addr;
  logic signed [7:0]    cfg_bias;
  logic                 cfg_err;
  logic                 clr_all;
  logic                 step_start;
  logic                 step_busy;
  logic                 step_done;
  logic                 evt_valid;
  logic                 evt_ready;
  logic [ID_W-1:0]      evt_id;
  logic [ID_W-1:0]      rd_addr;
  logic signed [7:0]    rd_v;

  qif_neuron_scheduler #(
    .NUM_NEURONS(NN),
    .V_RESET(-8'sd20),
    .V_PEAK(8'sd50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_bias(cfg_bias),
    .cfg_err(cfg_err),
    .clr_all(clr_all),
    .step_start(step_start),
    .step_busy(step_busy),
    .step_done(step_done),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .rd_addr(rd_addr),
    .rd_v(rd_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int mv [NN];
  int mb [NN];
  int exp_q [$];

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NN; i++) begin
      mv[i] = -20;
      mb[i] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_step();
    for (int i = 0; i < NN; i++) begin
      if (mv[i] >= 50) begin
        exp_q.push_back(i);
        mv[i] = -20;
      end else begin
        mv[i] = sat8(mv[i] + (mb[i] >>> 2) + (mv[i] * mv[i]) / 16);
      end
    end
  endfunction

  task automatic read_v(input int idx, output int val);
    rd_addr = ID_W'(idx);
    #1;
    val = int'(rd_v);
  endtask

  task automatic check_all_v(input string tag);
    int val;
    for (int i = 0; i < NN; i++) begin
      read_v(i, val);
      chk($sformatf("%s_v%0d", tag, i), val, mv[i]);
    end
  endtask

  task automatic cfg_write(input int addr, input int bias, input bit with_clr);
    cfg_we   = 1'b1;
    cfg_addr = ID_W'(addr);
    cfg_bias = 8'(bias);
    clr_all  = with_clr;
    tick();
    cfg_we  = 1'b0;
    clr_all = 1'b0;
    mb[addr] = bias;
    if (with_clr) begin
      for (int i = 0; i < NN; i++) mv[i] = -20;
    end
    chk("cfg_err_idle", cfg_err, 0);
  endtask

  // Drives one sweep, consumes events against the scoreboard, and optionally
  // fires config/start requests while the sweep is running.
  task automatic run_step(input int stall, input int exp_cycles, input bit poke);
    int cycles;
    int cur_id;
    int st;
    int expid;
    bit have;
    model_step();
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    cfg_we     = 1'b0;
    clr_all    = 1'b0;
    chk("busy_after_start", step_busy, 1);
    cycles = 1;
    have   = 1'b0;
    st     = 0;
    cur_id = 0;
    while (!step_done && cycles < 300) begin
      if (evt_valid) begin
        chk("busy_in_emit", step_busy, 1);
        if (!have) begin
          cur_id = int'(evt_id);
          have   = 1'b1;
          st     = stall;
        end else begin
          chk("evt_id_stable", int'(evt_id), cur_id);
        end
        if (st > 0) begin
          evt_ready = 1'b0;
          st--;
        end else begin
          evt_ready = 1'b1;
          if (exp_q.size() == 0) begin
            chk("evt_extra", int'(evt_id), -1);
          end else begin
            expid = exp_q.pop_front();
            chk("evt_id", int'(evt_id), expid);
          end
          have = 1'b0;
        end
      end else begin
        evt_ready = 1'b0;
      end
      if (poke) begin
        cfg_addr   = '0;
        cfg_bias   = 8'sd99;
        cfg_we     = (cycles == 1);
        clr_all    = (cycles == 2);
        step_start = (cycles == 2);
        if (cycles == 2 || cycles == 3) chk("cfg_err_busy", cfg_err, 1);
        if (cycles == 4) chk("cfg_err_clear", cfg_err, 0);
      end
      tick();
      cycles++;
    end
    evt_ready  = 1'b0;
    cfg_we     = 1'b0;
    clr_all    = 1'b0;
    step_start = 1'b0;
    chk("step_done_seen", step_done, 1);
    chk("busy_in_done", step_busy, 0);
    if (exp_cycles >= 0) chk("step_latency", cycles, exp_cycles);
    chk("events_left", exp_q.size(), 0);
    exp_q.delete();
    tick();
    chk("done_pulse", step_done, 0);
    chk("idle_busy", step_busy, 0);
    tick();
    chk("no_restart", step_busy, 0);
    check_all_v("post_step");
  endtask

  int val;
  int n;

  initial begin
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_bias   = '0;
    clr_all    = 1'b0;
    step_start = 1'b0;
    evt_ready  = 1'b0;
    rd_addr    = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_busy", step_busy, 0);
    chk("rst_done", step_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_evt_id", int'(evt_id), 0);
    for (int i = 0; i < NN; i++) begin
      read_v(i, val);
      chk("rst_v", val, -20);
    end
    rst_n = 1'b1;
    tick();

    // Plain step with zero bias: done N+1 cycles after start, every V -> 5
    run_step(0, NN + 1, 1'b0);
    read_v(2, val);
    chk("zero_bias_v2", val, 5);

    // Bias 40 on neuron 0: 15, 39, 127, then spike and reset
    cfg_write(0, 0, 1'b1);
    cfg_write(0, 40, 1'b0);
    run_step(0, NN + 1, 1'b0);
    read_v(0, val); chk("b40_step1_v0", val, 15);
    read_v(1, val); chk("b40_step1_v1", val, 5);
    run_step(0, NN + 1, 1'b0);
    read_v(0, val); chk("b40_step2_v0", val, 39);
    run_step(0, NN + 1, 1'b0);
    read_v(0, val); chk("b40_step3_v0_sat", val, 127);
    run_step(0, NN + 2, 1'b0);
    read_v(0, val); chk("b40_step4_v0_reset", val, -20);

    // Two spikes in one step with a stalled consumer
    cfg_write(0, 0, 1'b1);
    cfg_write(1, 40, 1'b0);
    cfg_write(3, 40, 1'b0);
    for (int s = 0; s < 3; s++) run_step(0, NN + 1, 1'b0);
    run_step(3, NN + 1 + 2 * 4, 1'b0);

    // Arithmetic edges: B=-128 and floor shift of B=-3
    cfg_write(0, -128, 1'b1);
    cfg_write(1, -20, 1'b0);
    cfg_write(3, 0, 1'b0);
    cfg_we   = 1'b1;
    cfg_addr = 2'd2;
    cfg_bias = 8'sd8;
    mb[2]    = 8;
    run_step(0, NN + 1, 1'b0);
    read_v(0, val); chk("neg128_v0", val, -27);
    read_v(1, val); chk("to_zero_v1", val, 0);
    read_v(2, val); chk("cfg_with_start_v2", val, 7);
    cfg_write(1, -3, 1'b0);
    run_step(0, NN + 1, 1'b0);
    read_v(1, val); chk("floor_shift_v1", val, -1);

    // Config, clear and start requests while busy are rejected
    run_step(0, NN + 1, 1'b1);
    run_step(0, NN + 1, 1'b0);

    // Reset while an event is pending
    cfg_write(0, 40, 1'b1);
    for (int s = 0; s < 3; s++) run_step(0, NN + 1, 1'b0);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    chk("pre_reset_evt_valid", evt_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_evt_valid", evt_valid, 0);
    chk("async_rst_busy", step_busy, 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    chk("post_rst_busy", step_busy, 0);
    check_all_v("post_rst");
    run_step(0, NN + 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
